// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
// It owns the fetch PC and talks to a variable-latency instruction memory,
// allowing one request in flight at a time. The hazard unit's stall and flush
// controls gate loads into IF/ID. Taken branches from EX and jumps from ID
// redirect the PC. A response that belongs to the wrong path is discarded.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   PC_en, IF_ID_en, IF_ID_clr  hazard-unit controls (clr wins over en)
//   D_jump, D_jump_target       jump resolved in ID
//   E_branch_taken/_target      taken branch resolved in EX (wins over jump)
//   imem_req/addr/ready         request handshake (combinational req/addr)
//   imem_rvalid/rdata           in-order response, at least 1 cycle after accept
//   D_instr/pc/pc_plus4/valid   IF/ID register contents
//   F_waiting                   no instruction available this cycle (combinational)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_en,
    input  logic        IF_ID_en,
    input  logic        IF_ID_clr,
    input  logic        D_jump,
    input  logic [31:0] D_jump_target,
    input  logic        E_branch_taken,
    input  logic [31:0] E_branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc_plus4,
    output logic        D_valid,
    output logic        F_waiting
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] f_pc, pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic            kill, kill_nxt;
    logic [XLEN-1:0] hold_buf, buf_nxt;
    logic            req_c;
    logic [XLEN-1:0] addr_c;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            avail;
    logic [XLEN-1:0] instr;
    logic            consume;

    // Redirect resolution: an EX branch is older than an ID jump, so it wins.
    assign redirect = E_branch_taken | (D_jump & PC_en);
    assign target   = E_branch_taken ? E_branch_target : D_jump_target;

    // An instruction is available from a live response or from the hold buffer.
    assign avail    = ((state == ST_WAIT) & imem_rvalid & ~kill) | (state == ST_HOLD);
    assign instr    = (state == ST_HOLD) ? hold_buf : imem_rdata;
    assign consume  = avail & PC_en & IF_ID_en & ~IF_ID_clr & ~redirect;
    assign pc_plus4 = f_pc + XLEN'(4);

    // Next-state and memory-request logic.
    always_comb begin
        state_nxt = state;
        pc_nxt    = f_pc;
        kill_nxt  = kill;
        buf_nxt   = hold_buf;
        req_c     = 1'b0;
        addr_c    = f_pc;
        case (state)
            ST_REQ: begin
                req_c = ~redirect;
                if (redirect) begin
                    pc_nxt = target;
                end else if (imem_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid && kill) begin
                    // Wrong-path response: drop it and refetch from F_pc.
                    kill_nxt  = 1'b0;
                    state_nxt = ST_REQ;
                    if (redirect) begin
                        pc_nxt = target;
                    end
                end else if (imem_rvalid && redirect) begin
                    pc_nxt    = target;
                    state_nxt = ST_REQ;
                end else if (consume) begin
                    // Back-to-back issue of the next sequential fetch.
                    pc_nxt    = pc_plus4;
                    req_c     = 1'b1;
                    addr_c    = pc_plus4;
                    state_nxt = imem_ready ? ST_WAIT : ST_REQ;
                end else if (imem_rvalid) begin
                    buf_nxt   = imem_rdata;
                    state_nxt = ST_HOLD;
                end else if (redirect) begin
                    // Request still in flight: mark it dead, keep waiting for it.
                    kill_nxt = 1'b1;
                    pc_nxt   = target;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = ST_REQ;
                end else if (consume) begin
                    pc_nxt    = pc_plus4;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    assign imem_req  = req_c & rst_n;
    assign imem_addr = addr_c;
    assign F_waiting = ~avail;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Fetch PC, kill flag and hold buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_pc     <= RESET_PC;
            kill     <= 1'b0;
            hold_buf <= '0;
        end else begin
            f_pc     <= pc_nxt;
            kill     <= kill_nxt;
            hold_buf <= buf_nxt;
        end
    end

    // IF/ID register: flush, load, bubble, or hold, in that priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D_valid    <= 1'b0;
            D_instr    <= NOP_INSTR;
            D_pc       <= '0;
            D_pc_plus4 <= XLEN'(4);
        end else if (IF_ID_clr) begin
            D_valid    <= 1'b0;
            D_instr    <= NOP_INSTR;
            D_pc       <= '0;
            D_pc_plus4 <= XLEN'(4);
        end else if (IF_ID_en && consume) begin
            D_valid    <= 1'b1;
            D_instr    <= instr;
            D_pc       <= f_pc;
            D_pc_plus4 <= pc_plus4;
        end else if (IF_ID_en) begin
            D_valid    <= 1'b0;
            D_instr    <= NOP_INSTR;
            D_pc       <= '0;
            D_pc_plus4 <= XLEN'(4);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural instruction memory with
// programmable latency, queues of expected request addresses and expected
// IF/ID contents, and a second instance with RESET_PC at the top of memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_en, ifid_en, ifid_clr;
    logic        d_jump, br;
    logic [31:0] d_jump_target, br_target;

    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] D_instr, D_pc, D_pc_plus4;
    logic        D_valid, F_waiting;

    logic        m2_req, m2_rvalid;
    logic [31:0] m2_addr, m2_rdata;
    logic [31:0] m2_instr, m2_pc, m2_pc_plus4;
    logic        m2_valid, m2_waiting;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .PC_en(pc_en), .IF_ID_en(ifid_en), .IF_ID_clr(ifid_clr),
        .D_jump(d_jump), .D_jump_target(d_jump_target),
        .E_branch_taken(br), .E_branch_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .D_instr(D_instr), .D_pc(D_pc), .D_pc_plus4(D_pc_plus4),
        .D_valid(D_valid), .F_waiting(F_waiting)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .PC_en(pc_en), .IF_ID_en(ifid_en), .IF_ID_clr(ifid_clr),
        .D_jump(d_jump), .D_jump_target(d_jump_target),
        .E_branch_taken(br), .E_branch_target(br_target),
        .imem_req(m2_req), .imem_addr(m2_addr), .imem_ready(1'b1),
        .imem_rvalid(m2_rvalid), .imem_rdata(m2_rdata),
        .D_instr(m2_instr), .D_pc(m2_pc), .D_pc_plus4(m2_pc_plus4),
        .D_valid(m2_valid), .F_waiting(m2_waiting)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] aq[$];
    logic [31:0] dq[$];
    int          lat;
    int          pend_cnt;
    logic        pend_v, p2_v;
    logic [31:0] pend_a, p2_a;
    logic [31:0] exp_dpc;
    logic        exp_dv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory outputs for the cycle that starts now.
    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend_v) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_a);
                pend_v      = 1'b0;
            end
        end
        m2_rvalid = p2_v;
        m2_rdata  = p2_v ? mem_word(p2_a) : $urandom;
        p2_v      = 1'b0;
    endtask

    // One clock cycle: record acceptance, clock, then check IF/ID.
    task automatic tick();
        logic        ld, clr;
        logic [31:0] e;
        #1;
        if (imem_req && imem_ready) begin
            check("addr_expected", 32'(aq.size() != 0), 32'd1);
            if (aq.size() != 0) begin
                e = aq.pop_front();
                check("imem_addr", imem_addr, e);
            end
            pend_v   = 1'b1;
            pend_a   = imem_addr;
            pend_cnt = lat;
        end
        if (m2_req) begin
            p2_v = 1'b1;
            p2_a = m2_addr;
        end
        ld  = ifid_en & ~ifid_clr;
        clr = ifid_clr;
        @(posedge clk);
        @(negedge clk);
        if (clr) begin
            check("flush_valid", 32'(D_valid), 32'd0);
            check("flush_instr", D_instr, NOP);
            check("flush_pc", D_pc, 32'd0);
            check("flush_pc4", D_pc_plus4, 32'd4);
            exp_dpc = 32'd0;
            exp_dv  = 1'b0;
        end else if (ld) begin
            if (D_valid) begin
                check("instr_expected", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    check("D_pc", D_pc, e);
                    check("D_instr", D_instr, mem_word(e));
                    check("D_pc_plus4", D_pc_plus4, e + 32'd4);
                    exp_dpc = e;
                    exp_dv  = 1'b1;
                end
            end else begin
                check("bubble_instr", D_instr, NOP);
                exp_dpc = 32'd0;
                exp_dv  = 1'b0;
            end
        end else begin
            check("hold_pc", D_pc, exp_dpc);
            check("hold_valid", 32'(D_valid), 32'(exp_dv));
        end
        mem_drive();
    endtask

    initial begin
        rst_n         = 1'b0;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_clr      = 1'b0;
        d_jump        = 1'b0;
        br            = 1'b0;
        d_jump_target = 32'd0;
        br_target     = 32'd0;
        imem_ready    = 1'b1;
        imem_rvalid   = 1'b1;
        imem_rdata    = 32'hDEAD_BEEF;
        m2_rvalid     = 1'b0;
        m2_rdata      = 32'd0;
        pend_v        = 1'b0;
        p2_v          = 1'b0;
        pend_a        = 32'd0;
        p2_a          = 32'd0;
        pend_cnt      = 0;
        lat           = 1;
        exp_dpc       = 32'd0;
        exp_dv        = 1'b0;

        // Reset: request suppressed, IF/ID holds the bubble.
        repeat (2) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_req2", 32'(m2_req), 32'd0);
        check("rst_valid", 32'(D_valid), 32'd0);
        check("rst_instr", D_instr, NOP);
        check("rst_pc", D_pc, 32'd0);
        check("rst_pc4", D_pc_plus4, 32'd4);

        rst_n = 1'b1;
        mem_drive();
        // A stray rvalid while in REQ must be ignored.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;

        // Sequential fetch with a load-use stall on the 0x8 response.
        foreach (aq[i]) aq.delete();
        aq.push_back(32'h0);  aq.push_back(32'h4);  aq.push_back(32'h8);
        aq.push_back(32'hC);  aq.push_back(32'h10);
        dq.push_back(32'h0);  dq.push_back(32'h4);  dq.push_back(32'h8);
        dq.push_back(32'hC);

        #1;
        check("first_addr", imem_addr, 32'h0);
        check("first_waiting", 32'(F_waiting), 32'd1);
        check("wrap_addr0", m2_addr, 32'hFFFF_FFFC);
        tick();                                     // cycle 0
        #1;
        check("resp_waiting", 32'(F_waiting), 32'd0);
        check("wrap_addr1", m2_addr, 32'h0);
        tick();                                     // cycle 1
        check("wrap_dpc", m2_pc, 32'hFFFF_FFFC);
        check("wrap_dpc4", m2_pc_plus4, 32'h0);
        check("wrap_valid", 32'(m2_valid), 32'd1);
        check("tput_valid1", 32'(D_valid), 32'd1);
        tick();                                     // cycle 2
        check("tput_valid2", 32'(D_valid), 32'd1);
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        tick();                                     // cycle 3: stall, 0x8 buffered
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_avail", 32'(F_waiting), 32'd0);
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        tick();                                     // cycle 4: buffered 0x8 consumed
        tick();                                     // cycle 5: request 0xC
        lat = 3;
        tick();                                     // cycle 6: request 0x10, slow
        lat = 1;

        // Branch to 0x100 while 0x10 is outstanding.
        aq.push_back(32'h100); aq.push_back(32'h104);
        dq.push_back(32'h100);
        br        = 1'b1;
        br_target = 32'h100;
        ifid_clr  = 1'b1;
        #1;
        check("br_req", 32'(imem_req), 32'd0);
        tick();                                     // cycle 7: kill set
        br       = 1'b0;
        ifid_clr = 1'b0;
        #1;
        check("kill_wait_req", 32'(imem_req), 32'd0);
        tick();                                     // cycle 8
        tick();                                     // cycle 9: 0x10 dropped
        check("kill_drop_valid", 32'(D_valid), 32'd0);
        #1;
        check("target_req", 32'(imem_req), 32'd1);
        tick();                                     // cycle 10: request 0x100
        tick();                                     // cycle 11: 0x100 into IF/ID

        // Jump to 0x20, then a jump to 0x40 on the 0x20 response.
        aq.push_back(32'h20); aq.push_back(32'h40); aq.push_back(32'h44);
        dq.push_back(32'h40);
        d_jump        = 1'b1;
        d_jump_target = 32'h20;
        ifid_clr      = 1'b1;
        tick();                                     // cycle 12
        d_jump   = 1'b0;
        ifid_clr = 1'b0;
        tick();                                     // cycle 13: request 0x20
        d_jump        = 1'b1;
        d_jump_target = 32'h40;
        ifid_clr      = 1'b1;
        tick();                                     // cycle 14: 0x20 discarded
        d_jump   = 1'b0;
        ifid_clr = 1'b0;
        tick();                                     // cycle 15: request 0x40
        tick();                                     // cycle 16

        // Simultaneous jump and branch: the branch target wins.
        aq.push_back(32'h80); aq.push_back(32'h84); aq.push_back(32'h88);
        aq.push_back(32'h8C); aq.push_back(32'h90); aq.push_back(32'h94);
        dq.push_back(32'h80); dq.push_back(32'h84); dq.push_back(32'h88);
        dq.push_back(32'h8C); dq.push_back(32'h90);
        d_jump        = 1'b1;
        d_jump_target = 32'h40;
        br            = 1'b1;
        br_target     = 32'h80;
        ifid_clr      = 1'b1;
        tick();                                     // cycle 17
        d_jump   = 1'b0;
        br       = 1'b0;
        ifid_clr = 1'b0;
        tick();                                     // cycle 18: request 0x80
        tick();                                     // cycle 19
        tick();                                     // cycle 20

        // Memory back-pressure during back-to-back issue.
        imem_ready = 1'b0;
        tick();                                     // cycle 21: 0x8C not accepted
        #1;
        check("bp_req", 32'(imem_req), 32'd1);
        check("bp_addr", imem_addr, 32'h8C);
        tick();                                     // cycle 22
        imem_ready = 1'b1;
        tick();                                     // cycle 23: request 0x8C
        tick();                                     // cycle 24
        tick();                                     // cycle 25

        check("dq_drained", 32'(dq.size()), 32'd0);
        check("aq_drained", 32'(aq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RISC-V core. It owns the fetch PC and issues requests to a variable-latency instruction memory with a one-outstanding-request handshake. It loads fetched instructions into the decode stage under the stall and flush controls produced by the hazard unit. Taken branches (from EX) and jumps (from ID) redirect it; in-flight responses for the wrong path are discarded.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- PC_en  in  1  hazard unit: PC may advance
- IF_ID_en  in  1  hazard unit: IF/ID may load
- IF_ID_clr  in  1  hazard unit: flush IF/ID (priority over IF_ID_en)
- D_jump  in  1  jump decoded in ID
- D_jump_target  in  32  jump target
- E_branch_taken  in  1  branch in EX resolved taken
- E_branch_target  in  32  branch target
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (byte address, [1:0]=0)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid (in order, ≥1 cycle after acceptance)
- imem_rdata  in  32  response instruction
- D_instr  out  32  IF/ID instruction
- D_pc  out  32  IF/ID PC
- D_pc_plus4  out  32  IF/ID PC+4
- D_valid  out  1  IF/ID holds a real instruction
- F_waiting  out  1  no instruction available this cycle (informational)

## Operation
- Registers: F_pc, state {REQ, WAIT, HOLD}, kill bit, 32-bit hold buffer, IF/ID register.
- redirect = E_branch_taken | (D_jump & PC_en); target = E_branch_taken ? E_branch_target : D_jump_target (branch wins).
- avail = (WAIT & imem_rvalid & !kill) | HOLD; instr = HOLD ? buffer : imem_rdata.
- consume = avail & PC_en & IF_ID_en & !IF_ID_clr & !redirect.
- REQ: imem_req = !redirect, imem_addr = F_pc. On redirect, F_pc ← target and stay in REQ. Otherwise, on imem_ready, go to WAIT.
- WAIT, rvalid & kill: kill ← 0, go to REQ (response dropped); a simultaneous redirect also loads F_pc.
- WAIT, rvalid & !kill & redirect: drop response, F_pc ← target, go to REQ.
- WAIT, consume: F_pc ← F_pc+4. Back-to-back issue: imem_req=1, imem_addr=F_pc+4. If imem_ready, stay in WAIT; otherwise go to REQ.
- WAIT, rvalid & !consume & !redirect (stalled): buffer ← imem_rdata, go to HOLD.
- WAIT, !rvalid & redirect: kill ← 1, F_pc ← target, stay in WAIT.
- HOLD: on redirect, F_pc ← target, go to REQ. On consume, F_pc ← F_pc+4, go to REQ. Otherwise hold.
- imem_req is 0 in WAIT except for the back-to-back case, and 0 in HOLD.
- IF/ID priority order:
  - IF_ID_clr: load bubble (D_valid=0, D_instr=NOP_INSTR, D_pc=0, D_pc_plus4=4).
  - Else IF_ID_en & consume: load instr, F_pc, F_pc+4, D_valid=1.
  - Else IF_ID_en: load bubble.
  - Else: hold.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- F_waiting = !avail.

## Timing
- Reset values (async): state=REQ, F_pc=RESET_PC, kill=0, buffer=0, D_valid=0, D_instr=NOP_INSTR, D_pc=0, D_pc_plus4=4. imem_req is forced to 0 while rst_n=0.
- First request: cycle after rst_n rises, imem_addr=RESET_PC.
- Latency: response in cycle N appears on D_* in N+1 when consumed.
- Throughput: one instruction per cycle with a 1-cycle memory and imem_ready held high.
- Redirect takes effect on imem_addr the cycle after the redirect cycle. At most one request is outstanding.
- A kill set in WAIT drops exactly the next rvalid. A request to the target issues in the cycle after that drop.
- Reset mid-transaction: all state is cleared. Any late rvalid after reset is ignored, because the state is REQ.

## Test plan
- Reset, 1-cycle memory, imem_ready=1, PC_en=IF_ID_en=1 → addresses 0,4,8,…; D_pc sequence 0,4,8 on consecutive cycles with D_valid=1.
- Load-use stall: PC_en=IF_ID_en=0 for 1 cycle while rvalid returns instr@8 → D_* held at pc 4. State goes to HOLD. Next cycle D_pc=8, then fetch 12 (no refetch of 8).
- E_branch_taken target 0x100 while the response for 0x10 is outstanding (rvalid 2 cycles later), with IF_ID_clr=1 → kill set. The 0x10 response is dropped and D_valid stays 0. The next imem_addr is 0x100; D_pc=0x100 follows.
- D_jump=1 with PC_en=1, target 0x40, same cycle as rvalid for 0x20, IF_ID_clr=1 → 0x20 is not loaded (bubble). The next request is 0x40.
- D_jump and E_branch_taken in the same cycle (targets 0x40 and 0x80) → next fetch is 0x80.
- RESET_PC=32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000. D_pc_plus4 of the first instruction is 0.
